// File: rtl/coprocessador_filtro.sv
// coprocessador_filtro: 3x3 edge-detection coprocessor streaming a RAM image.
// Optional macro COPROC_ABS_EN: use |A-B| so both edge polarities are detected.
module coprocessador_filtro #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 12,
    parameter int LIMIAR = 128
) (
    input  logic              clock_50MHz,
    input  logic              reset_n,
    input  logic              enable_start,
    input  logic              modo,
    input  logic [PIX_W-1:0]  q,
    output logic [ADDR_W-1:0] rdaddress,
    output logic [ADDR_W-1:0] wraddress,
    output logic              pixel,
    output logic              enable,
    output logic              ocupado,
    output logic              ACABOU
);

    localparam int SW = PIX_W + 2;
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [ADDR_W-1:0] WA   = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [XW-1:0]     XMAX = XW'(IMG_W - 1);
    localparam logic [YW-1:0]     YMAX = YW'(IMG_H - 1);
    localparam logic [SW-1:0]     SMAX = SW'((1 << PIX_W) - 1);
    localparam logic [31:0]       LIM  = 32'(LIMIAR);

    typedef enum logic [2:0] {
        IDLE,
        LER,
        CALC,
        COMP,
        ESCREVE,
        FIM
    } state_t;

    state_t state;
    state_t state_nx;

    logic [ADDR_W-1:0] addr;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [XW-1:0]     x_nx;
    logic [YW-1:0]     y_nx;
    logic              x_end;
    logic              last;
    logic              modo_r;
    logic [2:0]        cnt;
    logic [PIX_W-1:0]  smp [0:5];
    logic [SW-1:0]     a_sum;
    logic [SW-1:0]     b_sum;
    logic [SW-1:0]     d_val;
    logic              border_cur;

    // Border test on frame coordinates; border pixels are never read.
    function automatic logic is_border(input logic [XW-1:0] xv,
                                       input logic [YW-1:0] yv);
        is_border = (xv == '0) || (xv == XMAX) ||
                    (yv == '0) || (yv == YMAX);
    endfunction

    // Doubles a sample and saturates it at the pixel full scale.
    function automatic logic [SW-1:0] dbl(input logic [PIX_W-1:0] s);
        logic [SW-1:0] t;
        t = {1'b0, s, 1'b0};
        dbl = (t > SMAX) ? SMAX : t;
    endfunction

    // Neighbour address for read slot k; the first three slots feed A.
    function automatic logic [ADDR_W-1:0] rd_addr(
        input logic [ADDR_W-1:0] base,
        input logic [2:0]        k,
        input logic              m
    );
        logic [ADDR_W-1:0] up;
        logic [ADDR_W-1:0] dn;
        up = base - WA;
        dn = base + WA;
        case ({m, k})
            4'b0_000: rd_addr = up - ONE;
            4'b0_001: rd_addr = base - ONE;
            4'b0_010: rd_addr = dn - ONE;
            4'b0_011: rd_addr = up + ONE;
            4'b0_100: rd_addr = base + ONE;
            4'b0_101: rd_addr = dn + ONE;
            4'b1_000: rd_addr = up - ONE;
            4'b1_001: rd_addr = up;
            4'b1_010: rd_addr = up + ONE;
            4'b1_011: rd_addr = dn - ONE;
            4'b1_100: rd_addr = dn;
            4'b1_101: rd_addr = dn + ONE;
            default:  rd_addr = base;
        endcase
    endfunction

    assign x_end      = (x == XMAX);
    assign x_nx       = x_end ? '0 : x + XW'(1);
    assign y_nx       = x_end ? y + YW'(1) : y;
    assign last       = (addr == LAST);
    assign border_cur = is_border(x, y);

    assign wraddress = addr;
    assign enable    = (state == ESCREVE);
    assign pixel     = (state == ESCREVE) && !border_cur &&
                       ({{(32-SW){1'b0}}, d_val} >= LIM);

    // State register.
    always_ff @(posedge clock_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: interior pixels go through the read window.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (enable_start) begin
                    state_nx = is_border('0, '0) ? ESCREVE : LER;
                end
            end
            LER: begin
                if (cnt == 3'd6) begin
                    state_nx = CALC;
                end
            end
            CALC:    state_nx = COMP;
            COMP:    state_nx = ESCREVE;
            ESCREVE: begin
                if (last) begin
                    state_nx = FIM;
                end else if (is_border(x_nx, y_nx)) begin
                    state_nx = ESCREVE;
                end else begin
                    state_nx = LER;
                end
            end
            FIM:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: address walk, neighbour reads, sums and status flags.
    always_ff @(posedge clock_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            addr      <= '0;
            x         <= '0;
            y         <= '0;
            modo_r    <= 1'b0;
            cnt       <= '0;
            rdaddress <= '0;
            a_sum     <= '0;
            b_sum     <= '0;
            d_val     <= '0;
            ocupado   <= 1'b0;
            ACABOU    <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                smp[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (enable_start) begin
                        modo_r  <= modo;
                        ACABOU  <= 1'b0;
                        ocupado <= 1'b1;
                        addr    <= '0;
                        x       <= '0;
                        y       <= '0;
                        cnt     <= '0;
                        if (state_nx == LER) begin
                            rdaddress <= rd_addr('0, 3'd0, modo);
                        end
                    end
                end
                LER: begin
                    cnt <= cnt + 3'd1;
                    if (cnt < 3'd5) begin
                        rdaddress <= rd_addr(addr, cnt + 3'd1, modo_r);
                    end
                    if (cnt != 3'd0) begin
                        smp[cnt - 3'd1] <= q;
                    end
                end
                CALC: begin
                    a_sum <= dbl(smp[0]) + dbl(smp[1]) + dbl(smp[2]);
                    b_sum <= dbl(smp[3]) + dbl(smp[4]) + dbl(smp[5]);
                end
                COMP: begin
`ifdef COPROC_ABS_EN
                    d_val <= (a_sum >= b_sum) ? a_sum - b_sum
                                              : b_sum - a_sum;
`else
                    d_val <= (a_sum >= b_sum) ? a_sum - b_sum : '0;
`endif
                end
                ESCREVE: begin
                    if (last) begin
                        ACABOU  <= 1'b1;
                        ocupado <= 1'b0;
                    end else begin
                        addr <= addr + ONE;
                        x    <= x_nx;
                        y    <= y_nx;
                        cnt  <= '0;
                        if (state_nx == LER) begin
                            rdaddress <= rd_addr(addr + ONE, 3'd0, modo_r);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coprocessador_filtro.sv
// tb_coprocessador_filtro: directed + random frames against a neighbourhood model.
// Build with COPROC_ABS_EN defined to check the absolute-difference variant.
module tb_coprocessador_filtro;

    logic clk = 1'b0;
    logic reset_n;
    logic start_b, start_s;
    logic modo_b, modo_s;
    logic [7:0] q_b, q_s;

    logic [11:0] b_rd, b_wa;
    logic b_pix, b_en, b_oc, b_ac;
    logic [7:0] s_rd, s_wa;
    logic s_pix, s_en, s_oc, s_ac;
    logic [7:0] l_rd, l_wa;
    logic l_pix, l_en, l_oc, l_ac;

    logic [7:0] mem_b [4096];
    logic [7:0] mem_s [256];

    int n_tests = 0;
    int n_fail  = 0;
    int exp_rd [6];

    always #10 clk = ~clk;

    // Source RAMs with one cycle of read latency.
    always @(posedge clk) begin
        q_b <= mem_b[b_rd];
        q_s <= mem_s[s_rd];
    end

    coprocessador_filtro u_b (
        .clock_50MHz(clk), .reset_n(reset_n),
        .enable_start(start_b), .modo(modo_b), .q(q_b),
        .rdaddress(b_rd), .wraddress(b_wa), .pixel(b_pix),
        .enable(b_en), .ocupado(b_oc), .ACABOU(b_ac)
    );

    coprocessador_filtro #(
        .IMG_W(16), .IMG_H(16), .ADDR_W(8), .LIMIAR(128)
    ) u_s (
        .clock_50MHz(clk), .reset_n(reset_n),
        .enable_start(start_s), .modo(modo_s), .q(q_s),
        .rdaddress(s_rd), .wraddress(s_wa), .pixel(s_pix),
        .enable(s_en), .ocupado(s_oc), .ACABOU(s_ac)
    );

    coprocessador_filtro #(
        .IMG_W(16), .IMG_H(16), .ADDR_W(8), .LIMIAR(6)
    ) u_l (
        .clock_50MHz(clk), .reset_n(reset_n),
        .enable_start(start_s), .modo(modo_s), .q(q_s),
        .rdaddress(l_rd), .wraddress(l_wa), .pixel(l_pix),
        .enable(l_en), .ocupado(l_oc), .ACABOU(l_ac)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic int sat2(input int s);
        return (2 * s > 255) ? 255 : 2 * s;
    endfunction

    function automatic int px(input bit big, input int xx, input int yy);
        if (big) return int'(mem_b[yy * 64 + xx]);
        return int'(mem_s[yy * 16 + xx]);
    endfunction

    // Expected output bit: left/right columns (modo 0) or top/bottom rows (modo 1).
    function automatic int ref_pix(input bit big, input bit m, input int lim,
                                   input int xx, input int yy);
        int w, a, b, d;
        w = big ? 64 : 16;
        if (xx == 0 || yy == 0 || xx == w - 1 || yy == w - 1) return 0;
        a = 0;
        b = 0;
        for (int k = -1; k <= 1; k++) begin
            if (!m) begin
                a += sat2(px(big, xx - 1, yy + k));
                b += sat2(px(big, xx + 1, yy + k));
            end else begin
                a += sat2(px(big, xx + k, yy - 1));
                b += sat2(px(big, xx + k, yy + 1));
            end
        end
        d = a - b;
`ifdef COPROC_ABS_EN
        if (d < 0) d = -d;
`else
        if (d < 0) d = 0;
`endif
        return (d >= lim) ? 1 : 0;
    endfunction

    task automatic fill_s(input int kind);
        for (int i = 0; i < 256; i++) begin
            case (kind)
                0: mem_s[i] = 8'd100;
                1: mem_s[i] = (i % 16 < 8) ? 8'd1 : 8'd0;
                2: mem_s[i] = (i % 16 < 8) ? 8'd0 : 8'd200;
                3: mem_s[i] = 8'($urandom_range(40, 0));
                4: mem_s[i] = 8'($urandom_range(255, 0));
                default: mem_s[i] = (i % 16 < 8) ? 8'd200 : 8'd0;
            endcase
        end
    endtask

    // One 16x16 frame on both small instances; poke adds mid-frame
    // start/modo disturbances and a start during the done cycle.
    task automatic run_small(input bit m, input bit poke,
                             output int o_s, output int o_l);
        int cyc, ns, nl;
        bit done;
        @(negedge clk);
        modo_s  = m;
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        cyc = 1; ns = 0; nl = 0; o_s = 0; o_l = 0; done = 0;
        check("s_acabou_clr", s_ac, 0);
        check("s_busy", s_oc, 1);
        while (!done && cyc < 4000) begin
            if (s_en) begin
                check("s_wa", s_wa, ns);
                check("s_pix", s_pix, ref_pix(0, m, 128, ns % 16, ns / 16));
                o_s += int'(s_pix);
                ns++;
            end
            if (l_en) begin
                check("l_wa", l_wa, nl);
                check("l_pix", l_pix, ref_pix(0, m, 6, nl % 16, nl / 16));
                o_l += int'(l_pix);
                nl++;
            end
            if (s_ac) begin
                done = 1;
            end else begin
                if (poke) begin
                    start_s = (cyc == 300);
                    if (cyc == 500) modo_s = !m;
                end
                @(negedge clk);
                cyc++;
            end
        end
        check("s_done", done, 1);
        check("s_nwrites", ns, 256);
        check("l_nwrites", nl, 256);
        check("s_idle_busy", s_oc, 0);
        check("l_acabou", l_ac, 1);
        if (poke) begin
            start_s = 1'b1;
            @(negedge clk);
            start_s = 1'b0;
            repeat (3) @(negedge clk);
            check("fim_start_busy", s_oc, 0);
            check("fim_start_acabou", s_ac, 1);
            check("fim_start_en", s_en, 0);
        end
    endtask

    initial begin
        int cyc, nw, ones, c64, os, ol;
        bit done;
        reset_n = 1'b0;
        start_b = 1'b0;
        start_s = 1'b0;
        modo_b  = 1'b0;
        modo_s  = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            mem_b[i] = (i % 64 < 32) ? 8'd200 : 8'd0;
        end
        fill_s(0);
        exp_rd[0] = 0;  exp_rd[1] = 64;  exp_rd[2] = 128;
        exp_rd[3] = 2;  exp_rd[4] = 66;  exp_rd[5] = 130;

        repeat (3) @(negedge clk);
        check("rst_rd", b_rd, 0);
        check("rst_wa", b_wa, 0);
        check("rst_pix", b_pix, 0);
        check("rst_en", b_en, 0);
        check("rst_busy", b_oc, 0);
        check("rst_acabou", b_ac, 0);
        reset_n = 1'b1;

        // Full-size frame: vertical edge between columns 31 and 32.
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        cyc = 1; nw = 0; ones = 0; c64 = -100; done = 0;
        check("b_first_en", b_en, 1);
        check("b_first_wa", b_wa, 0);
        while (!done && cyc < 45000) begin
            if (cyc >= c64 + 1 && cyc <= c64 + 6) begin
                check("b_rdseq", b_rd, exp_rd[cyc - c64 - 1]);
            end
            if (b_en) begin
                check("b_wa", b_wa, nw);
                check("b_pix", b_pix, ref_pix(1, 0, 128, nw % 64, nw / 64));
                if (nw == 64) c64 = cyc;
                if (nw == 65) check("b_lat65", cyc - c64, 10);
                ones += int'(b_pix);
                nw++;
            end
            if (b_ac) begin
                done = 1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        check("b_done", done, 1);
        check("b_nwrites", nw, 4096);
        check("b_ones", ones, 124);
        check("b_busy_end", b_oc, 0);

        // Uniform image: no edges anywhere.
        fill_s(0);
        run_small(0, 0, os, ol);
        check("unif_s_ones", os, 0);
        check("unif_l_ones", ol, 0);

        // Weak step, D=6: only the LIMIAR=6 instance fires.
        fill_s(1);
        run_small(0, 1, os, ol);
        check("weak_s_ones", os, 0);
        check("weak_l_ones", ol, 28);

        // Rising step: negative difference.
        fill_s(2);
        run_small(0, 0, os, ol);
`ifdef COPROC_ABS_EN
        check("neg_s_ones", os, 28);
`else
        check("neg_s_ones", os, 0);
`endif

        // Vertical edge seen by the vertical kernel: nothing.
        fill_s(5);
        run_small(1, 0, os, ol);
        check("v_s_ones", os, 0);
        check("v_l_ones", ol, 0);

        fill_s(3);
        run_small(1, 0, os, ol);
        fill_s(4);
        run_small(0, 0, os, ol);

        // Reset in the middle of a frame, then a clean frame.
        fill_s(3);
        @(negedge clk);
        modo_s  = 1'b0;
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        repeat (999) @(negedge clk);
        check("mid_busy", s_oc, 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_rd", s_rd, 0);
        check("mid_rst_wa", s_wa, 0);
        check("mid_rst_pix", s_pix, 0);
        check("mid_rst_en", s_en, 0);
        check("mid_rst_busy", s_oc, 0);
        check("mid_rst_acabou", s_ac, 0);
        check("mid_rst_b_acabou", b_ac, 0);
        @(negedge clk);
        reset_n = 1'b1;
        run_small(1, 0, os, ol);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/coprocessador_filtro.md
COPROCESSADOR_FILTRO -- requirements
Module: coprocessador_filtro

Interface
REQ-001 Parameters (name, default, meaning): IMG_W, 64, image width in pixels; IMG_H, 64, image height in pixels; PIX_W, 8, input pixel width; ADDR_W, 12, RAM address width (>= clog2(IMG_W*IMG_H)); LIMIAR, 128, edge threshold.
REQ-002 Block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Ports (name, direction, width, meaning):
- clock_50MHz, in, 1, sole clock.
- reset_n, in, 1, async active-low reset.
- enable_start, in, 1, start request.
- modo, in, 1, kernel select: 0 horizontal, 1 vertical.
- q, in, PIX_W, source RAM read data.
- rdaddress, out, ADDR_W, source RAM read address.
- wraddress, out, ADDR_W, destination RAM write address.
- pixel, out, 1, destination write data.
- enable, out, 1, destination write strobe.
- ocupado, out, 1, busy.
- ACABOU, out, 1, frame done.

Function
REQ-004 Pixel address SHALL be y*IMG_W+x; frame pixels SHALL be processed in ascending address order, each written exactly once.
REQ-005 States SHALL be IDLE, LER, CALC, COMP, ESCREVE, FIM.
REQ-006 IDLE: enable_start=1 SHALL latch modo, clear ACABOU, set ocupado, select address 0, and go to ESCREVE if the pixel is on the border, else to LER.
REQ-007 Border pixels (x=0, x=IMG_W-1, y=0, y=IMG_H-1) SHALL be written with pixel=0 in a single ESCREVE cycle, with no reads.
REQ-008 LER SHALL last 7 cycles; addresses are issued on cycles 0-5 and q is captured on cycles 1-6, for a fixed source RAM latency of 1 cycle.
REQ-009 Read order for modo=0 SHALL be UL, L, DL, UR, R, DR. Read order for modo=1 SHALL be UL, U, UR, DL, D, DR.
REQ-010 CALC (1 cycle): each sample SHALL become s' = min(2*s, 2^PIX_W-1). Then A = first three s', B = last three s', each PIX_W+2 bits wide.
REQ-011 COMP (1 cycle): D = A-B when A>=B, else 0 (see REQ-019).
REQ-012 ESCREVE (1 cycle): enable=1, wraddress=current address, pixel=(D>=LIMIAR). enable SHALL be 0 in every other cycle.
REQ-013 After ESCREVE the block SHALL advance to the next address (LER or ESCREVE per REQ-006/007). After address IMG_W*IMG_H-1 it SHALL go to FIM.
REQ-014 Latency: interior pixel 10 cycles, border pixel 1 cycle.
REQ-015 FIM (1 cycle): ACABOU SHALL be set and ocupado cleared, then the block SHALL return to IDLE. ACABOU SHALL stay 1 until the next accepted start.
REQ-016 enable_start SHALL be ignored outside IDLE. A start in the same cycle as FIM SHALL NOT be accepted.
REQ-017 modo changes during a frame SHALL have no effect until the next start.

Reset
REQ-018 reset_n=0 SHALL asynchronously force state IDLE and set rdaddress, wraddress, pixel, enable, ocupado, ACABOU and all internal registers to 0. This applies at any point, including mid-frame, with no write issued.

Configuration
REQ-019 Macro COPROC_ABS_EN:
- Defined: COMP SHALL use D = |A-B|, detecting edges of both polarities.
- Undefined: negative differences SHALL clamp to 0, per REQ-011.

Verification
REQ-020 Uniform image, all 100, modo=0 -> 4096 writes at addresses 0..4095 in order, all pixel=0, then ACABOU=1 and ocupado=0.
REQ-021 Columns 0-31=200 and 32-63=0:
- modo=0 -> pixel=1 only at x=31 and x=32 for y=1..62, since D=765.
- modo=1 -> all pixel=0.
REQ-022 Columns 0-31=0 and 32-63=200, modo=0:
- Without COPROC_ABS_EN -> all pixel=0.
- With COPROC_ABS_EN -> pixel=1 at x=31 and x=32 for y=1..62.
REQ-023 Columns 0-31=1 and 32-63=0, modo=0 (D=6 at x=31,32):
- LIMIAR=6 -> pixel=1 at x=31,32.
- LIMIAR=7 -> all pixel=0.
REQ-024 Frame start: first address 0 is written with pixel=0 one cycle after start acceptance. For address 65, modo=0, rdaddress sequence SHALL be 0,64,128,2,66,130, and the write SHALL come 10 cycles after LER entry.
REQ-025 Reset and start handling:
- Pulse reset_n low 1000 cycles into a frame -> all outputs 0 immediately.
- enable_start pulses while ocupado=1 -> ignored.
- A new start after reset -> a complete 4096-write frame.
